// File: rtl/nonlinear_resp.sv
// -----------------------------------------------------------------------------
// nonlinear_resp
//
// Responder for the nonlinear-function stage of the estimator controller.
// It accepts one of three stage requests (prediction, new landmark, update)
// through a one-hot valid/ready handshake. It then reads LEN operand words
// from addresses 0..LEN-1. Each read index is carried through a PIPE_LAT-deep
// delay line that models the compute pipeline, and each index comes out as a
// write strobe at WR_BASE + index. After the last write, the block returns a
// completion: a one-hot echo of the accepted stage, held until the controller
// takes it.
//
// Optional feature (compile-time macro NL_RESP_TIMEOUT_EN):
//   defined   - an 8-bit counter runs while a completion waits. When TIMEOUT
//               cycles pass without a handshake, the sticky flag nl_timeout is
//               set. The completion stays asserted and can still be taken.
//   undefined - no counter is built and nl_timeout is tied to 0.
//
// Parameters:
//   AW       read/write address width
//   PRD_LEN  words read for a prediction request
//   NEW_LEN  words read for a new-landmark request
//   UPD_LEN  words read for an update request
//   PIPE_LAT read-to-write-back latency in cycles (1..15)
//   WR_BASE  write-back base address (the sum wraps modulo 2^AW)
//   TIMEOUT  completion wait limit in cycles (1..255)
//
// Ports:
//   clk              single clock, every register uses the rising edge
//   sys_rst          synchronous reset, active low
//   nonlinear_m_val  [2:0] one-hot stage request: 001 PRD, 010 NEW, 100 UPD
//   nonlinear_m_rdy  [2:0] controller ready for the completion, per stage
//   nonlinear_s_rdy  [2:0] 111 while idle, 000 otherwise
//   nonlinear_s_val  [2:0] completion valid, echo of the accepted stage
//   nl_rd_en         operand read strobe
//   nl_rd_addr       [AW-1:0] operand read address, 0 when nl_rd_en is low
//   nl_wr_en         result write strobe
//   nl_wr_addr       [AW-1:0] result write address, 0 when nl_wr_en is low
//   nl_busy          high whenever the state machine is not idle
//   nl_timeout       sticky completion-timeout flag
// -----------------------------------------------------------------------------
module nonlinear_resp #(
  parameter int AW       = 12,
  parameter int PRD_LEN  = 3,
  parameter int NEW_LEN  = 5,
  parameter int UPD_LEN  = 7,
  parameter int PIPE_LAT = 4,
  parameter int WR_BASE  = 'h800,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic [2:0]    nonlinear_m_val,
  input  logic [2:0]    nonlinear_m_rdy,
  output logic [2:0]    nonlinear_s_rdy,
  output logic [2:0]    nonlinear_s_val,
  output logic          nl_rd_en,
  output logic [AW-1:0] nl_rd_addr,
  output logic          nl_wr_en,
  output logic [AW-1:0] nl_wr_addr,
  output logic          nl_busy,
  output logic          nl_timeout
);

  localparam int MAX_LEN = (PRD_LEN > NEW_LEN) ?
                           ((PRD_LEN > UPD_LEN) ? PRD_LEN : UPD_LEN) :
                           ((NEW_LEN > UPD_LEN) ? NEW_LEN : UPD_LEN);
  // The read counter has to hold LEN itself, because that is its stop value.
  localparam int CW = $clog2(MAX_LEN + 1);

  // Marks every delay stage except the output stage. Once these bits are all
  // clear, the write strobe now leaving the pipe is the last one.
  localparam logic [PIPE_LAT-1:0] EARLY_MASK = PIPE_LAT'((1 << (PIPE_LAT - 1)) - 1);

  localparam logic [AW-1:0] BASE = AW'(WR_BASE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [2:0]    stage;
  logic [CW-1:0] len;
  logic [CW-1:0] rd_cnt;

  logic [PIPE_LAT-1:0] pipe_en;
  logic [AW-1:0]       pipe_addr [PIPE_LAT];

  logic early_pending;
  logic resp_fire;

  function automatic logic is_one_hot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [CW-1:0] len_of(input logic [2:0] v);
    case (v)
      3'b001:  return CW'(PRD_LEN);
      3'b010:  return CW'(NEW_LEN);
      default: return CW'(UPD_LEN);
    endcase
  endfunction

  assign early_pending = |(pipe_en & EARLY_MASK);
  // The completion is taken only on the captured stage's ready bit. Ready
  // bits for the other stages have no effect.
  assign resp_fire     = (state == RESP) && ((nonlinear_m_rdy & stage) != 3'b000);

  assign nl_wr_en   = pipe_en[PIPE_LAT-1];
  assign nl_wr_addr = pipe_addr[PIPE_LAT-1];
  assign nl_busy    = (state != IDLE);

  // Write-delay line. Each stage holds a strobe and a write address. The
  // address is masked to zero when the strobe is low, so nl_wr_addr stays 0
  // between writes without a mux at the output.
  // NOTE: this storage array is reset on purpose. A reset in the middle of a
  // run must clear any strobes still in flight. Otherwise a stale write would
  // appear after reset.
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      pipe_en <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_en[0]   <= nl_rd_en;
      pipe_addr[0] <= nl_rd_en ? (BASE + nl_rd_addr) : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // Control state machine. All of its outputs are registered. The first read
  // is issued on the accept edge itself, so the reads cover exactly the LEN
  // cycles in which the state is RUN.
  // NOTE: every state register uses non-blocking assignment. Each branch then
  // reads the values from before the edge, whatever order the statements are
  // written in.
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      state           <= IDLE;
      stage           <= '0;
      len             <= '0;
      rd_cnt          <= '0;
      nl_rd_en        <= 1'b0;
      nl_rd_addr      <= '0;
      nonlinear_s_rdy <= 3'b111;
      nonlinear_s_val <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          // Zero or multi-hot requests are ignored: nothing is captured and
          // the state does not change.
          if (is_one_hot(nonlinear_m_val)) begin
            stage           <= nonlinear_m_val;
            len             <= len_of(nonlinear_m_val);
            rd_cnt          <= CW'(1);
            nl_rd_en        <= 1'b1;
            nl_rd_addr      <= '0;
            nonlinear_s_rdy <= 3'b000;
            state           <= RUN;
          end
        end

        RUN: begin
          if (rd_cnt < len) begin
            nl_rd_en   <= 1'b1;
            nl_rd_addr <= AW'(rd_cnt);
            rd_cnt     <= rd_cnt + CW'(1);
          end else begin
            nl_rd_en   <= 1'b0;
            nl_rd_addr <= '0;
            state      <= DRAIN;
          end
        end

        DRAIN: begin
          if (nl_wr_en && !early_pending) begin
            nonlinear_s_val <= stage;
            state           <= RESP;
          end
        end

        RESP: begin
          if (resp_fire) begin
            nonlinear_s_val <= 3'b000;
            nonlinear_s_rdy <= 3'b111;
            state           <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef NL_RESP_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] to_cnt;

  // Counts the RESP cycles that pass without a handshake. When the count
  // reaches TIMEOUT, nl_timeout is set and stays set until reset. The counter
  // saturates, so an abandoned completion cannot make it wrap around.
  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      to_cnt     <= '0;
      nl_timeout <= 1'b0;
    end else if (state == RESP && !resp_fire) begin
      if (to_cnt == TO_LAST) nl_timeout <= 1'b1;
      if (to_cnt != 8'hFF)   to_cnt     <= to_cnt + 8'd1;
    end else if (state != RESP) begin
      to_cnt <= '0;
    end
  end
`else
  assign nl_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nonlinear_resp.sv
// -----------------------------------------------------------------------------
// tb_nonlinear_resp
//
// Directed, self-checking bench for nonlinear_resp with its default
// parameters. A table of complete transactions is driven through one
// generic task. For every cycle, the task works out the expected strobes,
// addresses, handshake outputs and busy flag from the stage length and the
// fixed latency. Hand-written sequences cover invalid requests, reset in
// the middle of a run, and the completion timeout.
//
// Cycle numbering: the edge that accepts a request is edge 0. Cycle c is the
// value the DUT presents between edge c-1 and edge c. The bench samples it
// 1 ns after edge c-1.
// -----------------------------------------------------------------------------
module tb_nonlinear_resp;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [2:0]  m_val = 3'b000;
  logic [2:0]  m_rdy = 3'b000;
  logic [2:0]  s_rdy;
  logic [2:0]  s_val;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;
  int cur_c    = 0;

  nonlinear_resp dut (
    .clk             (clk),
    .sys_rst         (sys_rst),
    .nonlinear_m_val (m_val),
    .nonlinear_m_rdy (m_rdy),
    .nonlinear_s_rdy (s_rdy),
    .nonlinear_s_val (s_val),
    .nl_rd_en        (rd_en),
    .nl_rd_addr      (rd_addr),
    .nl_wr_en        (wr_en),
    .nl_wr_addr      (wr_addr),
    .nl_busy         (busy),
    .nl_timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cur_c, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] val;       // request issued on the accept edge
    int         len;       // expected number of reads/writes
    int         rdy_cycle; // first cycle m_rdy carries the stage bit (0 = already high)
    logic [2:0] noise;     // other-stage m_rdy bits, held high throughout
    logic [2:0] intr;      // m_val driven while busy (must be ignored)
  } txn_t;

  task automatic run_txn(input txn_t t);
    int resp_start;
    int hs;
    logic [31:0] exp_wa;
    resp_start = t.len + P + 1;
    hs = (t.rdy_cycle > resp_start) ? t.rdy_cycle : resp_start;
    m_val = t.val;
    m_rdy = t.noise | ((t.rdy_cycle <= 0) ? t.val : 3'b000);
    tick; // accept edge
    for (int c = 1; c <= hs + 1; c++) begin
      cur_c = c;
      check("rd_en", 32'(rd_en), 32'(c >= 1 && c <= t.len));
      check("rd_addr", 32'(rd_addr), (c <= t.len) ? 32'(c - 1) : 32'd0);
      check("wr_en", 32'(wr_en), 32'(c >= 1 + P && c <= t.len + P));
      exp_wa = (c >= 1 + P && c <= t.len + P) ? 32'('h800 + c - 1 - P) : 32'd0;
      check("wr_addr", 32'(wr_addr), exp_wa);
      check("s_val", 32'(s_val), (c >= resp_start && c <= hs) ? 32'(t.val) : 32'd0);
      check("s_rdy", 32'(s_rdy), (c > hs) ? 32'h7 : 32'h0);
      check("busy", 32'(busy), 32'(c <= hs));
      m_val = (c <= hs) ? t.intr : 3'b000;
      m_rdy = (c <= hs) ? (t.noise | ((c >= t.rdy_cycle) ? t.val : 3'b000)) : 3'b000;
      tick;
    end
    m_val = 3'b000;
    m_rdy = 3'b000;
  endtask

  txn_t txns [4];

  initial begin
    logic exp_to;
    // Transaction table
    txns[0] = '{val: 3'b001, len: 3, rdy_cycle: 0,  noise: 3'b000, intr: 3'b000};
    txns[1] = '{val: 3'b100, len: 7, rdy_cycle: 20, noise: 3'b000, intr: 3'b011};
    txns[2] = '{val: 3'b010, len: 5, rdy_cycle: 13, noise: 3'b101, intr: 3'b001};
    txns[3] = '{val: 3'b001, len: 3, rdy_cycle: 9,  noise: 3'b110, intr: 3'b100};

    // Reset state
    sys_rst = 1'b0;
    tick;
    tick;
    cur_c = 0;
    check("rst s_rdy", 32'(s_rdy), 32'h7);
    check("rst s_val", 32'(s_val), 32'h0);
    check("rst rd_en", 32'(rd_en), 32'h0);
    check("rst wr_en", 32'(wr_en), 32'h0);
    check("rst rd_addr", 32'(rd_addr), 32'h0);
    check("rst wr_addr", 32'(wr_addr), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst timeout", 32'(timeout), 32'h0);
    sys_rst = 1'b1;
    tick;

    // Table-driven transactions
    for (int i = 0; i < 4; i++) run_txn(txns[i]);

    // Multi-hot and zero requests are ignored
    m_val = 3'b011;
    for (int c = 1; c <= 6; c++) begin
      cur_c = c;
      if (c == 3) m_val = 3'b111;
      if (c >= 5) m_val = 3'b000;
      tick;
      check("inv s_rdy", 32'(s_rdy), 32'h7);
      check("inv busy", 32'(busy), 32'h0);
      check("inv rd_en", 32'(rd_en), 32'h0);
      check("inv wr_en", 32'(wr_en), 32'h0);
    end

    // Reset asserted at cycle 3 of an update run
    m_val = 3'b100;
    tick;
    m_val = 3'b000;
    for (int c = 1; c <= 3; c++) begin
      cur_c = c;
      check("pre-rst rd_en", 32'(rd_en), 32'h1);
      check("pre-rst rd_addr", 32'(rd_addr), 32'(c - 1));
      if (c == 3) sys_rst = 1'b0;
      tick;
    end
    cur_c = 4;
    check("mid-rst busy", 32'(busy), 32'h0);
    check("mid-rst s_rdy", 32'(s_rdy), 32'h7);
    check("mid-rst rd_en", 32'(rd_en), 32'h0);
    check("mid-rst wr_en", 32'(wr_en), 32'h0);
    sys_rst = 1'b1;
    for (int c = 5; c <= 16; c++) begin
      tick;
      cur_c = c;
      check("post-rst wr_en", 32'(wr_en), 32'h0);
      check("post-rst s_val", 32'(s_val), 32'h0);
      check("post-rst busy", 32'(busy), 32'h0);
    end

    // Completion left waiting: timeout behaviour
    m_val = 3'b001;
    m_rdy = 3'b000;
    tick;
    m_val = 3'b000;
    for (int c = 1; c <= 300; c++) begin
      cur_c = c;
`ifdef NL_RESP_TIMEOUT_EN
      exp_to = (c >= 8 + 255);
`else
      exp_to = 1'b0;
`endif
      if (c == 7 || c == 8 || c == 262 || c == 263 || c == 300) begin
        check("to timeout", 32'(timeout), 32'(exp_to));
        check("to s_val", 32'(s_val), (c >= 8) ? 32'h1 : 32'h0);
      end
      if (c == 300) m_rdy = 3'b001;
      tick;
    end
    cur_c = 301;
    m_rdy = 3'b000;
    check("to done s_val", 32'(s_val), 32'h0);
    check("to done s_rdy", 32'(s_rdy), 32'h7);
`ifdef NL_RESP_TIMEOUT_EN
    check("to sticky", 32'(timeout), 32'h1);
`else
    check("to sticky", 32'(timeout), 32'h0);
`endif
    sys_rst = 1'b0;
    tick;
    sys_rst = 1'b1;
    check("to cleared", 32'(timeout), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
